// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (m0) and LSU (m1).
// One transaction in flight at a time; a WAIT-state timer turns a silent memory into an error response.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic                    m0_wen,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask,
  output logic                    m0_resp_valid,
  input  logic                    m0_resp_ready,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_resp_err,
  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic                    m1_wen,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask,
  output logic                    m1_resp_valid,
  input  logic                    m1_resp_ready,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_resp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy,
  output logic                    grant_id
);
  localparam int MW = DATA_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MW-1:0]         wmask_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  grant_q;
  logic                  last_q;
  logic [TW-1:0]         timer_q;

  logic any_req, win, resp_hs;

  // On a tie the master that did not own the last transaction wins.
  assign any_req = m0_req_valid | m1_req_valid;
  assign win     = (m0_req_valid & m1_req_valid) ? ~last_q : m1_req_valid;
  assign resp_hs = grant_q ? m1_resp_ready : m0_resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (any_req) begin
          addr_q  <= win ? m1_addr  : m0_addr;
          wen_q   <= win ? m1_wen   : m0_wen;
          wdata_q <= win ? m1_wdata : m0_wdata;
          wmask_q <= win ? m1_wmask : m0_wmask;
          grant_q <= win;
          state_q <= S_ISSUE;
        end
        S_ISSUE: if (mem_req_ready) begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end else if (timer_q == TMAX) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESP: if (resp_hs) begin
          last_q  <= grant_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ready is gated by rst so nothing is accepted while reset is asserted.
  assign m0_req_ready  = ~rst & (state_q == S_IDLE) & any_req & ~win;
  assign m1_req_ready  = ~rst & (state_q == S_IDLE) & any_req &  win;
  assign m0_resp_valid = (state_q == S_RESP) & ~grant_q;
  assign m1_resp_valid = (state_q == S_RESP) &  grant_q;
  assign m0_resp_err   = m0_resp_valid & err_q;
  assign m1_resp_err   = m1_resp_valid & err_q;
  assign m0_rdata      = rdata_q;
  assign m1_rdata      = rdata_q;
  assign mem_req_valid = (state_q == S_ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, round-robin, stalls, timeout, response backpressure, async reset.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req_valid = 0, m1_req_valid = 0;
  logic        m0_req_ready, m1_req_ready;
  logic [31:0] m0_addr = 0, m1_addr = 0;
  logic        m0_wen = 0, m1_wen = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic [3:0]  m0_wmask = 0, m1_wmask = 0;
  logic        m0_resp_valid, m1_resp_valid;
  logic        m0_resp_ready = 0, m1_resp_ready = 0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_resp_err, m1_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 0;
  logic [31:0] mem_rdata = 0;
  logic        busy, grant_id;

  int n_chk = 0;
  int n_fail = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
    .m0_rdata(m0_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
    .m1_rdata(m1_rdata), .m1_resp_err(m1_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory side of one transaction starting in ISSUE: accept now, respond in the first WAIT cycle.
  task automatic mem_serve(input logic [31:0] d);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    mem_resp_valid = 1;
    mem_rdata = d;
    tick();
    mem_resp_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_chk++; if ({m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, m0_resp_err, m1_resp_err, mem_req_valid} !== 7'b0)
      begin n_fail++; $display("FAIL reset_flags got=%b want=0", {m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, m0_resp_err, m1_resp_err, mem_req_valid}); end
    n_chk++; if ({mem_addr, mem_wdata, m0_rdata, mem_wmask, mem_wen, grant_id} !== '0)
      begin n_fail++; $display("FAIL reset_fields addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, m0_rdata); end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_read_latency();
    m0_req_valid = 1; m0_addr = 32'h8000_0000; m0_wen = 0;
    #1;
    n_chk++; if ({m0_req_ready, m1_req_ready} !== 2'b10) begin n_fail++; $display("FAIL rd_accept got=%b want=10", {m0_req_ready, m1_req_ready}); end
    tick();  // T+1
    m0_req_valid = 0;
    n_chk++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0)
      begin n_fail++; $display("FAIL rd_issue valid=%b addr=%h wen=%b want 1/80000000/0", mem_req_valid, mem_addr, mem_wen); end
    n_chk++; if (m0_req_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy ready=%b busy=%b want 0/1", m0_req_ready, busy); end
    mem_req_ready = 1;
    tick();  // T+2
    mem_req_ready = 0;
    n_chk++; if (mem_req_valid !== 1'b0 || m0_resp_valid !== 1'b0)
      begin n_fail++; $display("FAIL rd_wait mem_req_valid=%b resp_valid=%b want 0/0", mem_req_valid, m0_resp_valid); end
    mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
    tick();  // T+3
    mem_resp_valid = 0;
    n_chk++; if (m0_resp_valid !== 1'b1 || m0_rdata !== 32'h0000_0413 || m0_resp_err !== 1'b0 || m1_resp_valid !== 1'b0)
      begin n_fail++; $display("FAIL rd_resp valid=%b rdata=%h err=%b m1v=%b want 1/00000413/0/0", m0_resp_valid, m0_rdata, m0_resp_err, m1_resp_valid); end
    m0_resp_ready = 1;
    tick();
    m0_resp_ready = 0;
    n_chk++; if (busy !== 1'b0 || m0_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_done busy=%b resp_valid=%b want 0/0", busy, m0_resp_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_req_valid = 1; m0_addr = 32'h100;
    m1_req_valid = 1; m1_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      logic exp;
      exp = i[0];
      #1;
      n_chk++; if ({m1_req_ready, m0_req_ready} !== (exp ? 2'b10 : 2'b01))
        begin n_fail++; $display("FAIL rr_ready[%0d] m1m0=%b want %b", i, {m1_req_ready, m0_req_ready}, exp ? 2'b10 : 2'b01); end
      tick();
      n_chk++; if (grant_id !== exp || mem_addr !== (exp ? 32'h200 : 32'h100))
        begin n_fail++; $display("FAIL rr_grant[%0d] grant=%b addr=%h want %b", i, grant_id, mem_addr, exp); end
      mem_serve(32'h10 + i);
      n_chk++; if ({m1_resp_valid, m0_resp_valid} !== (exp ? 2'b10 : 2'b01) || m0_rdata !== 32'h10 + i)
        begin n_fail++; $display("FAIL rr_resp[%0d] m1m0=%b rdata=%h", i, {m1_resp_valid, m0_resp_valid}, m0_rdata); end
      n_chk++; if ({m0_req_ready, m1_req_ready} !== 2'b00) begin n_fail++; $display("FAIL rr_noaccept[%0d] got=%b want 00", i, {m0_req_ready, m1_req_ready}); end
      if (exp) m1_resp_ready = 1; else m0_resp_ready = 1;
      tick();
      m0_resp_ready = 0; m1_resp_ready = 0;
    end
    m0_req_valid = 0; m1_req_valid = 0;
  endtask

  task automatic test_write_stall();
    m1_req_valid = 1; m1_addr = 32'h8000_1000; m1_wen = 1; m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'b0011;
    #1;
    n_chk++; if (m1_req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_accept got=%b want 1", m1_req_ready); end
    tick();
    m1_req_valid = 0; m1_wen = 0; m1_wdata = 0; m1_wmask = 0; m1_addr = 0;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 1'b1 ||
                   mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'b0011 || grant_id !== 1'b1)
        begin n_fail++; $display("FAIL wr_stable[%0d] v=%b a=%h w=%b d=%h m=%b g=%b", i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, grant_id); end
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    n_chk++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wr_single got=%b want 0", mem_req_valid); end
    mem_resp_valid = 1; mem_rdata = 32'h55;
    tick();
    mem_resp_valid = 0;
    n_chk++; if (m1_resp_valid !== 1'b1 || m0_resp_valid !== 1'b0 || m1_resp_err !== 1'b0)
      begin n_fail++; $display("FAIL wr_resp m1v=%b m0v=%b err=%b want 1/0/0", m1_resp_valid, m0_resp_valid, m1_resp_err); end
    m1_resp_ready = 1;
    tick();
    m1_resp_ready = 0;
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 2; k++) begin
      m0_req_valid = 1; m0_addr = 32'h40 + k;
      tick();
      m0_req_valid = 0;
      mem_req_ready = 1;
      tick();  // first WAIT cycle
      mem_req_ready = 0;
      for (int w = 0; w < 3; w++) begin
        n_chk++; if (m0_resp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_early[%0d,%0d] resp_valid=%b want 0", k, w, m0_resp_valid); end
        tick();
      end
      n_chk++; if (m0_resp_valid !== 1'b0) begin n_fail++; $display("FAIL to_last_wait[%0d] resp_valid=%b want 0", k, m0_resp_valid); end
      if (k == 1) begin mem_resp_valid = 1; mem_rdata = 32'h0000_ABCD; end
      tick();
      mem_resp_valid = 0;
      n_chk++; if (m0_resp_valid !== 1'b1 || m0_resp_err !== (k == 0) || m0_rdata !== (k == 0 ? 32'h0 : 32'h0000_ABCD))
        begin n_fail++; $display("FAIL to_resp[%0d] valid=%b err=%b rdata=%h", k, m0_resp_valid, m0_resp_err, m0_rdata); end
      m0_resp_ready = 1;
      tick();
      m0_resp_ready = 0;
    end
  endtask

  task automatic test_resp_backpressure();
    m0_req_valid = 1; m0_addr = 32'h300;
    tick();
    m0_req_valid = 0;
    mem_serve(32'h1234);
    m1_req_valid = 1; m1_addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (m0_resp_valid !== 1'b1 || m0_rdata !== 32'h1234 || m1_req_ready !== 1'b0 || grant_id !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold[%0d] v=%b rdata=%h m1rdy=%b g=%b want 1/1234/0/0", i, m0_resp_valid, m0_rdata, m1_req_ready, grant_id); end
      tick();
    end
    m0_resp_ready = 1;
    tick();
    m0_resp_ready = 0;
    n_chk++; if (m1_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release m1_req_ready=%b want 1", m1_req_ready); end
    tick();
    m1_req_valid = 0;
    mem_serve(32'h5678);
    m1_resp_ready = 1;
    tick();
    m1_resp_ready = 0;
  endtask

  task automatic test_async_reset();
    m0_req_valid = 1; m0_addr = 32'h500;
    tick();
    m0_req_valid = 0;
    mem_req_ready = 1;
    tick();  // in WAIT
    mem_req_ready = 0;
    m0_resp_ready = 1; m1_req_valid = 1; m1_addr = 32'h600;
    #2;
    rst = 1;
    #1;
    n_chk++; if ({busy, mem_req_valid, m0_resp_valid, m1_resp_valid, m0_req_ready, m1_req_ready, grant_id} !== 7'b0 || mem_addr !== 32'h0)
      begin n_fail++; $display("FAIL ar_clear flags=%b addr=%h want 0", {busy, mem_req_valid, m0_resp_valid, m1_resp_valid, m0_req_ready, m1_req_ready, grant_id}, mem_addr); end
    tick();
    rst = 0;
    #1;
    n_chk++; if (m1_req_ready !== 1'b1) begin n_fail++; $display("FAIL ar_fresh_accept got=%b want 1", m1_req_ready); end
    tick();
    m1_req_valid = 0;
    n_chk++; if (mem_addr !== 32'h600 || grant_id !== 1'b1) begin n_fail++; $display("FAIL ar_issue addr=%h g=%b want 600/1", mem_addr, grant_id); end
    mem_serve(32'h77);
    n_chk++; if (m1_resp_valid !== 1'b1 || m1_rdata !== 32'h77 || m0_resp_valid !== 1'b0)
      begin n_fail++; $display("FAIL ar_resp m1v=%b rdata=%h m0v=%b want 1/77/0", m1_resp_valid, m1_rdata, m0_resp_valid); end
    m0_resp_ready = 0; m1_resp_ready = 1;
    tick();
    m1_resp_ready = 0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_done busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_round_robin();
    test_write_stall();
    test_timeout();
    test_resp_backpressure();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
